// File: rtl/quant_pkg.sv
// Shared constants and tables for the DCT coefficient quantizer.
// Holds the run geometry, the coefficient and result widths, the JPEG
// luminance quantization table and the fixed-point reciprocal table.
// The reciprocal table is built from LUMA_Q, so the two tables always agree.
package quant_pkg;

  localparam int NUM_WORDS = 32768;
  localparam int ADDR_W    = 15;
  localparam int CW        = 10;
  localparam int OW        = 8;
  localparam int RW        = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef logic [0:7][0:7][7:0]    qtab_t;
  typedef logic [0:7][0:7][RW-1:0] rtab_t;

  // Standard JPEG luminance table, row 0 first, column 0 first.
  localparam qtab_t LUMA_Q = '{
    '{8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61},
    '{8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55},
    '{8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56},
    '{8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62},
    '{8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77},
    '{8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92},
    '{8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101},
    '{8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99}
  };

  // round(2^RW / Q); no entry of the table lands on an exact half.
  function automatic rtab_t make_recip(input qtab_t q);
    rtab_t t;
    t = '0;
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 8; j++) begin
        t[r][j] = RW'(((1 << RW) + (int'(q[r][j]) >> 1)) / int'(q[r][j]));
      end
    end
    return t;
  endfunction

  localparam rtab_t RECIP = make_recip(LUMA_Q);

endpackage

// File: rtl/dct_quantizer_if.sv
// Memory-side bus of the quantizer: read port of the DCT output SRAM and
// write port of the quantized-image SRAM.
//   master: the quantizer (drives strobes/addresses/write data)
//   slave : the memories (return read data one cycle after rd_en)
interface dct_quantizer_if;
  import quant_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [8*CW-1:0]   rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [8*OW-1:0]   wr_data;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/quant_lane.sv
// One quantizer lane: a signed CW-bit coefficient times its reciprocal,
// rounded half away from zero, re-signed and saturated to OW bits.
// Two register stages: product (with sign), then the final result.
//   clk, reset : clock, synchronous active-high reset
//   coef       : signed coefficient (two's complement)
//   recip      : round(2^RW / Q) for this lane's table position
//   qout       : quantized, saturated result
module quant_lane
  import quant_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] coef,
  input  logic [RW-1:0] recip,
  output logic [OW-1:0] qout
);

  localparam logic [CW+RW:0] HALF    = {{(CW+1){1'b0}}, 1'b1, {(RW-1){1'b0}}};
  localparam logic [CW:0]    POS_MAX = (CW+1)'((1 << (OW-1)) - 1);
  localparam logic [CW:0]    NEG_MAX = (CW+1)'(1 << (OW-1));

  logic [CW-1:0]    mag;
  logic [CW+RW-1:0] prod_q;
  logic             neg_q;
  logic [CW+RW:0]   rounded;
  logic [CW:0]      qmag;
  logic [OW-1:0]    sat;

  // |coef|; -512 maps to 512, which still fits the unsigned CW-bit range.
  assign mag = coef[CW-1] ? CW'(~coef + CW'(1)) : coef;

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      neg_q  <= 1'b0;
    end else begin
      prod_q <= {{RW{1'b0}}, mag} * {{CW{1'b0}}, recip};
      neg_q  <= coef[CW-1];
    end
  end

  // Rounding on the magnitude gives half-away-from-zero once the sign is
  // re-applied; a zero magnitude stays zero for either sign.
  always_comb begin
    rounded = {1'b0, prod_q} + HALF;
    qmag    = rounded[CW+RW:RW];
    sat     = '0;
    if (neg_q) begin
      if (qmag > NEG_MAX) sat = OW'(NEG_MAX);
      else                sat = OW'(~qmag + (CW+1)'(1));
    end else begin
      if (qmag > POS_MAX) sat = OW'(POS_MAX);
      else                sat = OW'(qmag);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) qout <= '0;
    else       qout <= sat;
  end

endmodule

// File: rtl/dct_quantizer.sv
// DCT coefficient quantizer. On start, streams every row of the DCT output
// SRAM (8 x CW-bit signed lanes), quantizes each lane by the JPEG luminance
// table (row index = address[2:0]) and writes 8 x OW-bit rows back out.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle request, honoured only in IDLE
//   busy       : run in progress (RUN or DRAIN)
//   done       : one-cycle pulse the cycle after the last write
//   bus        : memory read/write port (master side)
// Pipeline: read a at n, data at n+1, products at n+2, write at n+3.
module dct_quantizer
  import quant_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  dct_quantizer_if.master bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_active;
  logic              last_rd;
  logic              v1_q, v2_q, wr_en_q;
  logic [ADDR_W-1:0] a1_q, a2_q, wr_addr_q;
  logic [8*OW-1:0]   lane_data;

  assign rd_active = (state_q == ST_RUN);
  assign last_rd   = (rd_addr_q == ADDR_W'(NUM_WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // DRAIN ends once the final valid slot is being written and nothing
  // remains behind it in the pipeline.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (last_rd) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_en_q && !v1_q && !v2_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The read counter parks at the last address instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      rd_addr_q <= '0;
    end else if (rd_active && !last_rd) begin
      rd_addr_q <= rd_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      a1_q      <= '0;
      a2_q      <= '0;
      wr_addr_q <= '0;
    end else begin
      v1_q    <= rd_active;
      v2_q    <= v1_q;
      wr_en_q <= v2_q;
      if (rd_active) a1_q <= rd_addr_q;
      if (v1_q)      a2_q <= a1_q;
      if (v2_q)      wr_addr_q <= a2_q;
    end
  end

  // a1_q is aligned with rd_data, so its low bits pick the table row.
  for (genvar j = 0; j < 8; j++) begin : g_lane
    quant_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .coef  (bus.rd_data[CW*j +: CW]),
      .recip (RECIP[a1_q[2:0]][j]),
      .qout  (lane_data[OW*j +: OW])
    );
  end

  // Strobes are masked by reset so nothing is issued in the reset cycle.
  assign bus.rd_en   = rd_active & ~reset;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q & ~reset;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = lane_data;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_dct_quantizer.sv
// Self-checking bench for dct_quantizer. A behavioural SRAM feeds read data
// one cycle after rd_en; every read pushes the expected quantized row onto a
// scoreboard, and every write pops and compares it. Scenario tasks check
// reset values, directed lane results, run timing, ignored starts and a
// mid-run reset followed by a clean all-zero run.
module tb_dct_quantizer;
  import quant_pkg::*;

  localparam int TB_Q [8][8] = '{
    '{16, 11, 10, 16, 24,  40,  51,  61},
    '{12, 12, 14, 19, 26,  58,  60,  55},
    '{14, 13, 16, 24, 40,  57,  69,  56},
    '{14, 17, 22, 29, 51,  87,  80,  62},
    '{18, 22, 37, 56, 68,  109, 103, 77},
    '{24, 35, 55, 64, 81,  104, 113, 92},
    '{49, 64, 78, 87, 103, 121, 120, 101},
    '{72, 92, 95, 98, 112, 100, 103, 99}
  };
  localparam int RUN_CYCLES = NUM_WORDS + 5;

  typedef struct {
    int          addr;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  dct_quantizer_if bus();

  dct_quantizer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [79:0] mem    [NUM_WORDS];
  logic [63:0] outmem [NUM_WORDS];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          writes = 0;
  int          done_pulses = 0;
  int          exp_rd = 0;

  function automatic logic [63:0] model_row(input int addr, input logic [79:0] d);
    logic [63:0] res;
    int r, c, q, rc, mag, qq;
    res = '0;
    r = addr % 8;
    for (int j = 0; j < 8; j++) begin
      c   = int'($signed(d[10*j +: 10]));
      q   = TB_Q[r][j];
      rc  = (65536 + q / 2) / q;
      mag = (c < 0) ? -c : c;
      qq  = (mag * rc + 32768) / 65536;
      if (c < 0) qq = -qq;
      if (qq > 127) qq = 127;
      if (qq < -128) qq = -128;
      res[8*j +: 8] = 8'(qq);
    end
    return res;
  endfunction

  // Read SRAM model: data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      exp_rd = 0;
    end else begin
      if (start && !busy && !done) exp_rd = 0;
      if (bus.wr_en) begin
        writes++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_underflow wr_addr %0d wr_data %h with no expected row", bus.wr_addr, bus.wr_data);
        end else begin
          e = sb.pop_front();
          if (int'(bus.wr_addr) !== e.addr || bus.wr_data !== e.data) begin
            errors++;
            $display("[TB] FAIL sb_write got addr %0d data %h expected addr %0d data %h", bus.wr_addr, bus.wr_data, e.addr, e.data);
          end
        end
        outmem[bus.wr_addr] = bus.wr_data;
      end
      if (bus.rd_en) begin
        checks++;
        if (int'(bus.rd_addr) !== exp_rd) begin
          errors++;
          $display("[TB] FAIL rd_addr_seq got %0d expected %0d", bus.rd_addr, exp_rd);
        end
        e.addr = exp_rd;
        e.data = model_row(int'(bus.rd_addr), mem[bus.rd_addr]);
        sb.push_back(e);
        exp_rd++;
      end
      if (done) done_pulses++;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL rst_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0)        begin errors++; $display("[TB] FAIL rst_done got %b expected 0", done); end
    checks++; if (bus.rd_en !== 1'b0)   begin errors++; $display("[TB] FAIL rst_rd_en got %b expected 0", bus.rd_en); end
    checks++; if (bus.wr_en !== 1'b0)   begin errors++; $display("[TB] FAIL rst_wr_en got %b expected 0", bus.wr_en); end
    checks++; if (bus.rd_addr !== '0)   begin errors++; $display("[TB] FAIL rst_rd_addr got %0d expected 0", bus.rd_addr); end
    checks++; if (bus.wr_addr !== '0)   begin errors++; $display("[TB] FAIL rst_wr_addr got %0d expected 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== '0)   begin errors++; $display("[TB] FAIL rst_wr_data got %h expected 0", bus.wr_data); end
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  // Directed and random data, extra start pulses during RUN, DRAIN and DONE.
  task automatic test_directed_run();
    int w_base, d_base, done_cycle;
    for (int i = 0; i < NUM_WORDS; i++) mem[i] = '0;
    for (int i = 64; i < 320; i++) mem[i] = 80'({$urandom, $urandom, $urandom});
    mem[0][9:0]   = 10'd160;
    mem[0][29:20] = 10'd511;
    mem[8][9:0]   = 10'h360;
    mem[16][9:0]  = 10'd8;
    mem[24][9:0]  = 10'h3F8;
    mem[7][79:70] = 10'h200;
    mem[15][79:70] = 10'h200;
    w_base = writes;
    d_base = done_pulses;
    done_cycle = 0;
    start = 1'b1;
    for (int k = 2; k <= RUN_CYCLES + 100 && done_cycle == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) begin
        checks++; if (bus.rd_en !== 1'b1) begin errors++; $display("[TB] FAIL first_rd_en got %b expected 1", bus.rd_en); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("[TB] FAIL busy_after_start got %b expected 1", busy); end
      end
      if (k == 500 || k == NUM_WORDS + 3) start = 1'b1;
      if (done) begin
        done_cycle = k;
        start = 1'b1;
      end
    end
    checks++;
    if (done_cycle != RUN_CYCLES) begin
      errors++;
      $display("[TB] FAIL run_done_cycle got %0d expected %0d", done_cycle, RUN_CYCLES);
    end
    repeat (2) begin
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b0 || bus.rd_en !== 1'b0) begin errors++; $display("[TB] FAIL start_at_done busy %b rd_en %b expected 0 0", busy, bus.rd_en); end
    end
    repeat (3) @(negedge clk);
    checks++; if (writes - w_base != NUM_WORDS)  begin errors++; $display("[TB] FAIL run_writes got %0d expected %0d", writes - w_base, NUM_WORDS); end
    checks++; if (done_pulses - d_base != 1)     begin errors++; $display("[TB] FAIL run_done_pulses got %0d expected 1", done_pulses - d_base); end
    checks++; if (sb.size() != 0)                begin errors++; $display("[TB] FAIL run_sb_left got %0d expected 0", sb.size()); end
    checks++; if (outmem[0][7:0] !== 8'd10)      begin errors++; $display("[TB] FAIL lane_160 got %h expected 0a", outmem[0][7:0]); end
    checks++; if (outmem[0][23:16] !== 8'd51)    begin errors++; $display("[TB] FAIL lane_511 got %h expected 33", outmem[0][23:16]); end
    checks++; if (outmem[8][7:0] !== 8'hF6)      begin errors++; $display("[TB] FAIL lane_m160 got %h expected f6", outmem[8][7:0]); end
    checks++; if (outmem[16][7:0] !== 8'h01)     begin errors++; $display("[TB] FAIL half_pos got %h expected 01", outmem[16][7:0]); end
    checks++; if (outmem[24][7:0] !== 8'hFF)     begin errors++; $display("[TB] FAIL half_neg got %h expected ff", outmem[24][7:0]); end
    checks++; if (outmem[7][63:56] !== 8'hFB)    begin errors++; $display("[TB] FAIL row7_w7 got %h expected fb", outmem[7][63:56]); end
    checks++; if (outmem[15][63:56] !== 8'hFB)   begin errors++; $display("[TB] FAIL row7_w15 got %h expected fb", outmem[15][63:56]); end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < NUM_WORDS; i++) mem[i] = '0;
    start = 1'b1;
    for (int k = 2; k <= 1000; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL wr_in_reset_cycle got %b expected 0", bus.wr_en); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL abort_status busy %b done %b expected 0 0", busy, done); end
    checks++; if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL abort_strobes rd_en %b wr_en %b expected 0 0", bus.rd_en, bus.wr_en); end
    checks++; if (bus.rd_addr !== '0 || bus.wr_addr !== '0 || bus.wr_data !== '0) begin errors++; $display("[TB] FAIL abort_buses rd_addr %0d wr_addr %0d wr_data %h expected 0 0 0", bus.rd_addr, bus.wr_addr, bus.wr_data); end
    @(negedge clk);
  endtask

  task automatic test_zero_run();
    int w_base, d_base, done_cycle, nonzero;
    w_base = writes;
    d_base = done_pulses;
    done_cycle = 0;
    start = 1'b1;
    for (int k = 2; k <= RUN_CYCLES + 100 && done_cycle == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) begin
        checks++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== '0) begin errors++; $display("[TB] FAIL restart_addr rd_en %b rd_addr %0d expected 1 0", bus.rd_en, bus.rd_addr); end
      end
      if (done) done_cycle = k;
    end
    checks++;
    if (done_cycle != RUN_CYCLES) begin
      errors++;
      $display("[TB] FAIL zero_done_cycle got %0d expected %0d", done_cycle, RUN_CYCLES);
    end
    repeat (3) @(negedge clk);
    nonzero = 0;
    for (int i = 0; i < NUM_WORDS; i++) if (outmem[i] !== '0) nonzero++;
    checks++; if (nonzero != 0)                  begin errors++; $display("[TB] FAIL zero_rows_nonzero got %0d expected 0", nonzero); end
    checks++; if (writes - w_base != NUM_WORDS)  begin errors++; $display("[TB] FAIL zero_writes got %0d expected %0d", writes - w_base, NUM_WORDS); end
    checks++; if (done_pulses - d_base != 1)     begin errors++; $display("[TB] FAIL zero_done_pulses got %0d expected 1", done_pulses - d_base); end
    checks++; if (sb.size() != 0)                begin errors++; $display("[TB] FAIL zero_sb_left got %0d expected 0", sb.size()); end
  endtask

  initial begin
    $display("[TB] starting dct_quantizer bench");
    test_reset();
    test_directed_run();
    test_reset_midrun();
    test_zero_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
